// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I and D requesters; D wins unless MEM_ARBITER_STARVE_GUARD_EN forces I.
// Grant->ready is MEM_LATENCY+1 cycles; requesters hold req until their ready pulse, which is the only backpressure.
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy,
  output logic [15:0]          num_conflict
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t               state_q, state_d;
  logic [3:0]           lat_q, lat_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] m_addr_q, m_addr_d;
  logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic [15:0]          conflict_q, conflict_d;
  logic                 force_i;
  logic                 grant_d_en;
  logic                 grant_i_en;
  logic                 last_beat;

  assign grant_d_en = (state_q == IDLE) && d_req && !force_i;
  assign grant_i_en = (state_q == IDLE) && i_req && !grant_d_en;
  assign last_beat  = (lat_q == 4'(MEM_LATENCY - 1));

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  // Only D grants that actually bypass a waiting I count towards starvation.
  assign force_i = i_req && (starve_q == 3'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (grant_d_en && i_req && (starve_q != 3'(STARVE_LIMIT))) begin
      starve_d = starve_q + 3'd1;
    end else if (grant_i_en) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
  assign force_i             = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    we_d       = we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    conflict_d = conflict_q;
    unique case (state_q)
      IDLE: begin
        lat_d = '0;
        if (i_req && d_req && (conflict_q != 16'hFFFF)) conflict_d = conflict_q + 16'd1;
        if (grant_d_en) begin
          state_d   = BUSY_D;
          we_d      = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (grant_i_en) begin
          state_d  = BUSY_I;
          we_d     = 1'b0;
          m_addr_d = i_addr;
        end
      end
      BUSY_I: begin
        lat_d = lat_q + 4'd1;
        if (last_beat) begin
          state_d   = RESP_I;
          i_rdata_d = m_rdata;
        end
      end
      BUSY_D: begin
        lat_d = lat_q + 4'd1;
        if (last_beat) begin
          state_d = RESP_D;
          if (!we_q) d_rdata_d = m_rdata;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      we_q       <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      we_q       <= we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      conflict_q <= conflict_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign m_read       = (state_q == BUSY_I) || ((state_q == BUSY_D) && !we_q);
  assign m_write      = (state_q == BUSY_D) && we_q;
  assign i_ready      = (state_q == RESP_I);
  assign d_ready      = (state_q == RESP_D);
  assign busy         = (state_q != IDLE);
  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign num_conflict = conflict_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, data and address width.
REQ-002 Parameter MEM_LATENCY, default 2, cycles the memory port is held per access (legal range 1..15).
REQ-003 Parameter STARVE_LIMIT, default 3, consecutive D grants tolerated while I waits (legal range 1..7).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_req  in  1  instruction-side read request, held until i_ready.
REQ-007 i_addr  in  WORD_SIZE  instruction address.
REQ-008 i_rdata  out  WORD_SIZE  instruction read data, valid while i_ready=1.
REQ-009 i_ready  out  1  one-cycle completion pulse, I side.
REQ-010 d_req  in  1  data-side request, held until d_ready.
REQ-011 d_we  in  1  1=write, 0=read.
REQ-012 d_addr, d_wdata  in  WORD_SIZE each  data address, write data.
REQ-013 d_rdata  out  WORD_SIZE  data read result, valid while d_ready=1.
REQ-014 d_ready  out  1  one-cycle completion pulse, D side.
REQ-015 m_read, m_write  out  1 each  shared memory strobes.
REQ-016 m_addr, m_wdata  out  WORD_SIZE each  shared memory address, write data.
REQ-017 m_rdata  in  WORD_SIZE  shared memory read data.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 num_conflict  out  16  saturating count of cycles in IDLE with i_req=d_req=1.

Function
REQ-020 States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D; no other states reachable.
REQ-021 IDLE: grant D if d_req and not starvation-forced; else grant I if i_req; else stay IDLE.
REQ-022 On grant edge T, addr/we/wdata of winner latched; requester inputs ignored until its ready pulse.
REQ-023 BUSY_x lasts exactly MEM_LATENCY cycles (T+1..T+MEM_LATENCY); m_addr/m_wdata stable; m_read=1 (I or D read) or m_write=1 (D write), never both.
REQ-024 m_rdata sampled at final BUSY edge into winner's rdata register; write leaves d_rdata unchanged.
REQ-025 RESP_x lasts one cycle (T+MEM_LATENCY+1): x_ready=1, strobes low; then IDLE unconditionally.
REQ-026 Latency grant->ready = MEM_LATENCY+1 cycles; throughput one access per MEM_LATENCY+2 cycles.
REQ-027 i_rdata/d_rdata hold last captured value until next completion on same side.
REQ-028 Requester dropping req mid-transaction does not abort it; ready still pulses.
REQ-029 m_read, m_write low in IDLE and RESP_x.
REQ-030 num_conflict increments per qualifying IDLE cycle, saturates at 16'hFFFF, no wrap.

Reset
REQ-031 reset=1 forces IDLE asynchronously; m_read, m_write, i_ready, d_ready, busy = 0 immediately.
REQ-032 Reset clears i_rdata, d_rdata, m_addr, m_wdata, num_conflict, starvation counter to 0.
REQ-033 Reset mid-transaction drops it silently: no ready pulse after release; first post-reset grant no earlier than first rising edge with reset=0.

Configuration
REQ-034 Macro MEM_ARBITER_STARVE_GUARD_EN defined: 3-bit counter incremented (saturating at STARVE_LIMIT) on each D grant with i_req=1, cleared on I grant; counter==STARVE_LIMIT with i_req=1 forces I grant over D.
REQ-035 Macro undefined: counter absent; strict D priority; I may starve indefinitely.

Verification
REQ-036 i_req only, i_addr=16'h0010, m_rdata=16'hBEEF, MEM_LATENCY=2 -> m_read high 2 cycles, i_ready at grant+3, i_rdata=16'hBEEF.
REQ-037 d_req+d_we, d_addr=16'h0040, d_wdata=16'h1234 -> m_write high 2 cycles with those values, d_ready pulse, d_rdata unchanged, m_read never high.
REQ-038 i_req and d_req rise same edge -> D served first, I granted next IDLE; num_conflict=1.
REQ-039 GUARD_EN, STARVE_LIMIT=3, i_req and d_req held high continuously -> grant order D,D,D,I,D,D,D,I; without macro all grants D.
REQ-040 reset pulsed during BUSY_D cycle 1 -> m_write falls same cycle, no d_ready ever, state IDLE, num_conflict=0.
